// File: rtl/divisor_restador.sv
// Sequential unsigned restoring divider: one trial subtraction per clock,
// start/busy/done handshake, results held until the next completed division.
module divisor_restador #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q, q_n, d, d_n;
  logic [WIDTH:0]   r, r_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             busy_n, done_n, dz_n;
  logic [WIDTH-1:0] quo_n, rem_n;

  // shifted partial remainder / quotient and the trial subtraction
  logic [WIDTH:0]   r_sh, trial;
  logic [WIDTH-1:0] q_sh, q_it;
  logic [WIDTH:0]   r_it;

  always_comb begin
    r_sh  = {r[WIDTH-1:0], q[WIDTH-1]};
    q_sh  = {q[WIDTH-2:0], 1'b0};
    trial = r_sh - {1'b0, d};
    if (!trial[WIDTH]) begin
      r_it = trial;
      q_it = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_it = r_sh;
      q_it = q_sh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      q           <= '0;
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      q           <= q_n;
      d           <= d_n;
      r           <= r_n;
      cnt         <= cnt_n;
      busy        <= busy_n;
      done        <= done_n;
      quotient    <= quo_n;
      remainder   <= rem_n;
      div_by_zero <= dz_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q;
    d_n     = d;
    r_n     = r;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = done;
    quo_n   = quotient;
    rem_n   = remainder;
    dz_n    = div_by_zero;
    case (state)
      IDLE: begin
        if (start) begin
          q_n     = a;
          d_n     = b;
          r_n     = '0;
          cnt_n   = CW'(WIDTH);
          busy_n  = 1'b1;
          state_n = (b == '0) ? FIN : CALC;
        end
      end
      CALC: begin
        q_n   = q_it;
        r_n   = r_it;
        cnt_n = cnt - 1'b1;
        // last iteration publishes results directly so done rises with FIN
        if (cnt == CW'(1)) begin
          state_n = FIN;
          quo_n   = q_it;
          rem_n   = r_it[WIDTH-1:0];
          dz_n    = 1'b0;
          done_n  = 1'b1;
        end
      end
      FIN: begin
        // done still low here only on the divide-by-zero path
        if (!done) begin
          quo_n  = '1;
          rem_n  = q;
          dz_n   = 1'b1;
          done_n = 1'b1;
        end else begin
          done_n  = 1'b0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/divisor_restador.md
Name: divisor_restador

Overview:
- Sequential unsigned restoring divider; the iterative stage that consumes the team's combinational subtract/borrow result.
- Performs one trial subtraction per clock: partial remainder minus divisor. The borrow decides restore/keep and sets the quotient bit.
- Sits between operand registers and result consumers in the arithmetic datapath. Uses a start/busy/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits (min 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  dividend, captured on accepted start
b  input  WIDTH  divisor, captured on accepted start
busy  output  1  high from the cycle after an accepted start through the done cycle
done  output  1  one-cycle pulse, results valid
quotient  output  WIDTH  unsigned a/b
remainder  output  WIDTH  unsigned a mod b
div_by_zero  output  1  set with done when the captured b==0

Behaviour:
- Single clock domain. rst is sampled on the rising clk edge (synchronous) and is active-high.
- Reset (also mid-operation) forces the following, and any in-flight division is discarded:
  - state=IDLE
  - busy=0, done=0, div_by_zero=0
  - quotient=0, remainder=0
  - internal counter/registers cleared
- FSM states: IDLE, CALC, FIN.
- IDLE, start=1 at edge E0:
  - latch Q=a, D=b; R=0 (WIDTH+1 bits); cnt=WIDTH
  - next state CALC, or FIN directly if b==0
  - busy=1 from E0
  - done, quotient, remainder, div_by_zero keep old values until FIN.
- IDLE, start=0: hold; outputs keep last results.
- CALC, one iteration per edge:
  - shift {R,Q} left 1
  - trial = R_shifted - {1'b0,D} (WIDTH+1 bits)
  - trial MSB=0 (no borrow): R=trial, Q[0]=1
  - trial MSB=1 (borrow): R unchanged (restore), Q[0]=0
  - cnt decrements each edge; on the iteration where cnt reaches 0, next state FIN.
- FIN, entered at edge E_WIDTH:
  - quotient=Q, remainder=R[WIDTH-1:0], div_by_zero=0, done=1, busy=1
  - next edge → IDLE with done=0, busy=0.
- Latency (normal): done high in the cycle following edge E0+WIDTH, i.e. WIDTH+1 cycles after start is sampled. Throughput: one division per WIDTH+2 cycles.
- Divide by zero:
  - E0 → FIN; done high after E1
  - quotient = all ones (2^WIDTH-1), remainder=a, div_by_zero=1
  - no CALC iterations.
- start while busy=1 (CALC or FIN): ignored, no queuing. Operands a/b may change freely after capture.
- start=1 in the cycle done=1: ignored. A new start is accepted only once back in IDLE.
- Results are stable and held until the next FIN. div_by_zero is cleared at the next FIN of a nonzero division.
- Invariant: quotient*b + remainder == a and remainder < b for all b≠0.
- No overflow is possible for unsigned division. The internal WIDTH+1-bit remainder prevents trial-subtraction wrap-around.

Test Plan:
- Reset, then a=100, b=7, start for 1 cycle → exactly 9 cycles later done=1 for one cycle, quotient=14, remainder=2, div_by_zero=0, busy drops the following cycle.
- a=255,b=1 → q=255,r=0; a=5,b=9 → q=0,r=5; a=200,b=200 → q=1,r=0; a=0,b=3 → q=0,r=0.
- a=77, b=0 → done 2 cycles after start, quotient=255, remainder=77, div_by_zero=1; next division 9/2 → q=4, r=1, div_by_zero=0.
- Start 100/7, then at cycle 3 drive start=1 with a=50,b=5 → ignored; result still q=14,r=2; one done pulse only.
- Start 100/7, assert rst at cycle 4 → next cycle busy=0, done=0, quotient=0, remainder=0; no done pulse; fresh 9/3 afterwards → q=3,r=0.
- 100 random a,b pairs (b≠0, plus forced b=0 cases) back-to-back → compare with integer reference a/b, a%b and the invariant; print "error" on any mismatch.
